bs_mac_acc: RTL and testbench
=============================

BS_MAC_ACC -- requirements
Module: bs_mac_acc

Interface
REQ-001 SHALL have parameter IWIDTH, default 16, meaning the maximum serial operand precision in bits.
REQ-002 SHALL have parameter AWIDTH, default 32, meaning the signed accumulator and result width.
REQ-003 SHALL have parameter CNTW, default $clog2(IWIDTH+1), meaning the width of the precision and bit-counter fields.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 clr  in  1  synchronous clear; highest priority after reset.
REQ-007 start  in  1  begin one MAC; sampled only in IDLE, or in HOLD on the handshake cycle.
REQ-008 prec  in  CNTW  runtime precision, sampled with start.
REQ-009 sgn  in  1  operand mode, sampled with start; 1 = two's-complement multiplier, 0 = unsigned.
REQ-010 pp_valid  in  1  the pp input carries one partial product.
REQ-011 pp  in  AWIDTH signed  partial product for the current multiplier bit, MSB first.
REQ-012 sum_i_valid  in  1  the upstream partial sum is valid.
REQ-013 sum_i  in  AWIDTH signed  upstream partial sum.
REQ-014 sum_i_ready  out  1  asserted exactly when the state is MERGE.
REQ-015 sum_o_valid  out  1  sum_o holds a completed result.
REQ-016 sum_o  out  AWIDTH signed  result register.
REQ-017 sum_o_ready  in  1  downstream accepts sum_o.
REQ-018 busy  out  1  asserted whenever the state is not IDLE.
REQ-019 ovf  out  1  sticky saturation flag.

Function
REQ-020 SHALL implement the FSM states IDLE, SHIFT, MERGE and HOLD.
REQ-021 IDLE: when start=1, SHALL capture sgn, load cnt from prec (prec=0 or prec>IWIDTH loads IWIDTH), clear the shift register sh, set first=1 and go to SHIFT.
REQ-022 SHIFT: pp is ignored when pp_valid=0 and the FSM stalls with no state change.
REQ-023 SHIFT: on each pp_valid cycle, SHALL set sh = sat((sh<<1) + t), where t = -pp if first and sgn are both 1, else t = pp; then clear first and decrement cnt.
REQ-024 SHIFT: on the pp_valid cycle where cnt==1, SHALL go to MERGE after the update.
REQ-025 MERGE: when sum_i_valid=1, SHALL set sum_o = sat(sum_i + sh), set sum_o_valid=1 and go to HOLD.
REQ-026 MERGE: when sum_i_valid=0, SHALL wait with no state change.
REQ-027 HOLD: sum_o and sum_o_valid SHALL stay stable until sum_o_ready=1.
REQ-028 HOLD: on the handshake cycle, SHALL clear sum_o_valid and go to IDLE; if start=1 on that same cycle, SHALL instead apply REQ-021 and go directly to SHIFT.
REQ-029 start SHALL be ignored in SHIFT and MERGE, and in HOLD on any cycle other than the handshake cycle.
REQ-030 Latency: start sampled at edge E0, with pp_valid held at 1 and sum_i_valid at 1, SHALL give sum_o_valid=1 after edge E(p+1), where p is the effective precision.
REQ-031 Arithmetic: every add SHALL be computed in AWIDTH+2 bits.
REQ-032 Saturation: sat() SHALL clamp to [-2^(AWIDTH-1), 2^(AWIDTH-1)-1].
REQ-033 Any clamp SHALL set ovf=1; ovf clears only on clr or reset.
REQ-034 pp and sum_i SHALL be ignored outside SHIFT and MERGE respectively.
REQ-035 clr=1 SHALL, in any state, force IDLE and zero sh, cnt, sum_o, sum_o_valid and ovf on the next edge; a simultaneous start is ignored.

Reset
REQ-036 rst_n=0 SHALL asynchronously force IDLE, sh=0, cnt=0, first=0, sum_o=0, sum_o_valid=0 and ovf=0.
REQ-037 Reset asserted mid-operation SHALL abandon the operation without emitting a result.
REQ-038 After rst_n is released, busy=0 and sum_i_ready=0 SHALL hold until the first accepted start.

Structure
REQ-039 Package bs_acc_pkg SHALL hold the state enum type (IDLE, SHIFT, MERGE, HOLD).
REQ-040 bs_acc_pkg SHALL also hold the default parameter constants.
REQ-041 One sub-module, sat_add, SHALL implement a parametrised signed (AWIDTH+2)-bit add with clamp to AWIDTH bits and a clamp flag.
REQ-042 sat_add SHALL be instantiated twice: once for the shift path and once for the merge path.

Verification
REQ-043 Unsigned: prec=4, sgn=0, pp=3,0,3,3, sum_i=100 -> sh steps 3,6,15,33; sum_o=133 valid after E5.
REQ-044 Signed: prec=4, sgn=1, multiplier -5 (1011) times 3, pp=3,0,3,3, sum_i=0 -> sh steps -3,-6,-9,-15; sum_o=-15; ovf=0.
REQ-045 Saturation: sh=0x20, sum_i=0x7FFFFFF0 -> sum_o=0x7FFFFFFF, ovf=1; ovf stays 1 through the next MAC until clr.
REQ-046 Stalls: pp_valid gaps of 3 cycles between bits, and sum_i_valid late by 5 cycles -> same result as REQ-043; sum_i_ready high only in MERGE.
REQ-047 Backpressure: sum_o_ready=0 for 10 cycles with start pulses -> sum_o stable and starts ignored; then sum_o_ready=1 with start=1 -> SHIFT on the next cycle with no IDLE gap.
REQ-048 Abort: clr in mid-SHIFT, and separately rst_n=0 in MERGE -> IDLE, sum_o=0, sum_o_valid=0; the following MAC returns a correct result.

Source files
------------

// File: rtl/bs_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bs_acc_pkg
// Brief    : Shared types and default sizing for the bit-serial MAC accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package bs_acc_pkg;

    localparam int c_IWIDTH_DEF = 16;
    localparam int c_AWIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MERGE = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
// Module   : sat_add
// Brief    : Signed (W+2)-bit adder clamped to the signed W-bit range.
// Revision : 1.0 - initial release
// ============================================================================
module sat_add #(
    parameter int W = 32
) (
    input  logic signed [W+1:0] a,
    input  logic signed [W+1:0] b,
    output logic signed [W-1:0] y,
    output logic                clamp
);

    localparam logic signed [W+1:0] c_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] c_MIN = {3'b111, {(W-1){1'b0}}};

    logic signed [W+1:0] w_sum;

    assign w_sum = a + b;

    always_comb begin
        clamp = 1'b0;
        y     = w_sum[W-1:0];
        if (w_sum > c_MAX) begin
            y     = c_MAX[W-1:0];
            clamp = 1'b1;
        end else if (w_sum < c_MIN) begin
            y     = c_MIN[W-1:0];
            clamp = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bs_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : bs_mac_acc
// Brief    : Bit-serial MAC: shift-accumulates MSB-first partial products, then
//            merges with an upstream partial sum under a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bs_mac_acc
    import bs_acc_pkg::*;
#(
    parameter int IWIDTH = c_IWIDTH_DEF,
    parameter int AWIDTH = c_AWIDTH_DEF,
    parameter int CNTW   = $clog2(IWIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     start,
    input  logic [CNTW-1:0]          prec,
    input  logic                     sgn,
    input  logic                     pp_valid,
    input  logic signed [AWIDTH-1:0] pp,
    input  logic                     sum_i_valid,
    input  logic signed [AWIDTH-1:0] sum_i,
    output logic                     sum_i_ready,
    output logic                     sum_o_valid,
    output logic signed [AWIDTH-1:0] sum_o,
    input  logic                     sum_o_ready,
    output logic                     busy,
    output logic                     ovf
);

    localparam logic [CNTW-1:0] c_IW  = CNTW'(IWIDTH);
    localparam logic [CNTW-1:0] c_ONE = CNTW'(1);

    state_e                   r_state, w_state_nxt;
    logic [CNTW-1:0]          r_cnt;
    logic signed [AWIDTH-1:0] r_sh, r_sum_o;
    logic                     r_first, r_sgn, r_sum_o_valid, r_ovf;

    logic                     w_release, w_take_start, w_shift_en, w_merge_en;
    logic [CNTW-1:0]          w_eff_prec;
    logic signed [AWIDTH+1:0] w_sh_x, w_sh_dbl, w_pp_x, w_term, w_sum_i_x;
    logic signed [AWIDTH-1:0] w_shift_y, w_merge_y;
    logic                     w_shift_clamp, w_merge_clamp;

    assign w_release    = (r_state == HOLD) && sum_o_ready;
    assign w_take_start = start && ((r_state == IDLE) || w_release);
    assign w_shift_en   = (r_state == SHIFT) && pp_valid;
    assign w_merge_en   = (r_state == MERGE) && sum_i_valid;
    assign w_eff_prec   = ((prec == '0) || (prec > c_IW)) ? c_IW : prec;

    // Two guard bits keep 2*sh + pp and sum_i + sh exact before clamping.
    assign w_sh_x    = {{2{r_sh[AWIDTH-1]}}, r_sh};
    assign w_sh_dbl  = w_sh_x <<< 1;
    assign w_pp_x    = {{2{pp[AWIDTH-1]}}, pp};
    assign w_term    = (r_first && r_sgn) ? -w_pp_x : w_pp_x;
    assign w_sum_i_x = {{2{sum_i[AWIDTH-1]}}, sum_i};

    sat_add #(.W(AWIDTH)) u_sat_shift (
        .a     (w_sh_dbl),
        .b     (w_term),
        .y     (w_shift_y),
        .clamp (w_shift_clamp)
    );

    sat_add #(.W(AWIDTH)) u_sat_merge (
        .a     (w_sum_i_x),
        .b     (w_sh_x),
        .y     (w_merge_y),
        .clamp (w_merge_clamp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (pp_valid && (r_cnt == c_ONE)) w_state_nxt = MERGE;
            MERGE:   if (sum_i_valid) w_state_nxt = HOLD;
            HOLD:    if (sum_o_ready) w_state_nxt = start ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (clr) w_state_nxt = IDLE;
    end

    always_comb begin
        busy        = (r_state != IDLE);
        sum_i_ready = (r_state == MERGE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_sh          <= '0;
            r_first       <= 1'b0;
            r_sgn         <= 1'b0;
            r_sum_o       <= '0;
            r_sum_o_valid <= 1'b0;
            r_ovf         <= 1'b0;
        end else if (clr) begin
            r_cnt         <= '0;
            r_sh          <= '0;
            r_first       <= 1'b0;
            r_sum_o       <= '0;
            r_sum_o_valid <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            if (w_release) r_sum_o_valid <= 1'b0;
            if (w_take_start) begin
                r_sgn   <= sgn;
                r_cnt   <= w_eff_prec;
                r_sh    <= '0;
                r_first <= 1'b1;
            end
            if (w_shift_en) begin
                r_sh    <= w_shift_y;
                r_first <= 1'b0;
                r_cnt   <= r_cnt - c_ONE;
                if (w_shift_clamp) r_ovf <= 1'b1;
            end
            if (w_merge_en) begin
                r_sum_o       <= w_merge_y;
                r_sum_o_valid <= 1'b1;
                if (w_merge_clamp) r_ovf <= 1'b1;
            end
        end
    end

    assign sum_o       = r_sum_o;
    assign sum_o_valid = r_sum_o_valid;
    assign ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bs_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bs_mac_acc
// Brief    : Self-checking bench for bs_mac_acc against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bs_mac_acc;

    localparam int IW = 16;
    localparam int AW = 32;
    localparam int CW = $clog2(IW + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr = 1'b0;
    logic                 start = 1'b0;
    logic [CW-1:0]        prec = '0;
    logic                 sgn = 1'b0;
    logic                 pp_valid = 1'b0;
    logic signed [AW-1:0] pp = '0;
    logic                 sum_i_valid = 1'b0;
    logic signed [AW-1:0] sum_i = '0;
    logic                 sum_i_ready;
    logic                 sum_o_valid;
    logic signed [AW-1:0] sum_o;
    logic                 sum_o_ready = 1'b0;
    logic                 busy;
    logic                 ovf;

    bs_mac_acc #(.IWIDTH(IW), .AWIDTH(AW), .CNTW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .start       (start),
        .prec        (prec),
        .sgn         (sgn),
        .pp_valid    (pp_valid),
        .pp          (pp),
        .sum_i_valid (sum_i_valid),
        .sum_i       (sum_i),
        .sum_i_ready (sum_i_ready),
        .sum_o_valid (sum_o_valid),
        .sum_o       (sum_o),
        .sum_o_ready (sum_o_ready),
        .busy        (busy),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    bit     m_ovf   = 1'b0;
    longint exp_res;
    longint pp_q[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint satf(input longint v, inout bit c);
        longint hi = (longint'(1) <<< (AW - 1)) - 1;
        longint lo = -(longint'(1) <<< (AW - 1));
        if (v > hi) begin c = 1'b1; return hi; end
        if (v < lo) begin c = 1'b1; return lo; end
        return v;
    endfunction

    // Model: multiplier bits MSB first select the multiplicand; the sign bit
    // carries negative weight when sgn is set.
    task automatic build(input int p_raw, input bit s, input longint mcand,
                         input longint mult, input longint sumi);
        int     p = ((p_raw == 0) || (p_raw > IW)) ? IW : p_raw;
        longint sh = 0;
        longint v, t;
        pp_q.delete();
        for (int i = 0; i < p; i++) begin
            v = (((mult >> (p - 1 - i)) & 1) != 0) ? mcand : 0;
            pp_q.push_back(v);
            t  = (i == 0 && s) ? -v : v;
            sh = satf(2 * sh + t, m_ovf);
        end
        exp_res = satf(sumi + sh, m_ovf);
    endtask

    task automatic begin_mac(input int p_raw, input bit s);
        start = 1'b1;
        prec  = CW'(p_raw);
        sgn   = s;
        @(negedge clk);
        start = 1'b0;
        prec  = CW'($urandom);
        sgn   = 1'($urandom);
        check("busy_after_start", longint'(busy), 1);
    endtask

    task automatic feed_bits(input int gap, input bit early, input longint sumi);
        logic signed [AW-1:0] v;
        if (early) begin
            sum_i_valid = 1'b1;
            v = sumi[AW-1:0];
            sum_i = v;
        end
        foreach (pp_q[i]) begin
            repeat (gap) begin
                pp_valid = 1'b0;
                pp       = $urandom;
                start    = 1'($urandom);
                @(negedge clk);
            end
            pp_valid = 1'b1;
            v        = pp_q[i][AW-1:0];
            pp       = v;
            start    = 1'($urandom);
            @(negedge clk);
        end
        pp_valid = 1'b0;
        pp       = $urandom;
        start    = 1'b0;
        check("ready_in_merge", longint'(sum_i_ready), 1);
        check("no_early_result", longint'(sum_o_valid), 0);
    endtask

    task automatic merge_check(input int late, input longint sumi, input string tag);
        logic signed [AW-1:0] v;
        repeat (late) begin
            sum_i_valid = 1'b0;
            sum_i       = $urandom;
            start       = 1'($urandom);
            @(negedge clk);
            check("ready_wait", longint'(sum_i_ready), 1);
        end
        sum_i_valid = 1'b1;
        v           = sumi[AW-1:0];
        sum_i       = v;
        @(negedge clk);
        sum_i_valid = 1'b0;
        sum_i       = $urandom;
        start       = 1'b0;
        check({tag, "_valid"}, longint'(sum_o_valid), 1);
        check({tag, "_sum"}, longint'(sum_o), exp_res);
        check({tag, "_ovf"}, longint'(ovf), longint'(m_ovf));
        check({tag, "_ready_low"}, longint'(sum_i_ready), 0);
    endtask

    task automatic accept();
        sum_o_ready = 1'b1;
        @(negedge clk);
        sum_o_ready = 1'b0;
        check("valid_cleared", longint'(sum_o_valid), 0);
        check("idle_after_accept", longint'(busy), 0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        m_ovf = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_valid", longint'(sum_o_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", longint'(busy), 0);
        check("post_rst_ready", longint'(sum_i_ready), 0);
        check("post_rst_sum", longint'(sum_o), 0);
        check("post_rst_ovf", longint'(ovf), 0);

        // Unsigned 3 * 1011b + 100, back-to-back bits and sum: result after E5
        build(4, 1'b0, 3, 11, 100);
        check("model_unsigned", exp_res, 133);
        begin_mac(4, 1'b0);
        feed_bits(0, 1'b1, 100);
        merge_check(0, 100, "unsigned");
        accept();

        // Signed multiplier -5 times 3
        build(4, 1'b1, 3, 11, 0);
        check("model_signed", exp_res, -15);
        begin_mac(4, 1'b1);
        feed_bits(0, 1'b1, 0);
        merge_check(0, 0, "signed");
        accept();

        // Stalls on both inputs
        build(4, 1'b0, 3, 11, 100);
        begin_mac(4, 1'b0);
        feed_bits(3, 1'b0, 100);
        merge_check(5, 100, "stall");

        // Backpressure: held result, starts ignored, then release + restart
        repeat (10) begin
            start = 1'($urandom);
            prec  = CW'($urandom);
            @(negedge clk);
            check("bp_sum_stable", longint'(sum_o), 133);
            check("bp_valid_stable", longint'(sum_o_valid), 1);
            check("bp_ready_low", longint'(sum_i_ready), 0);
        end
        build(4, 1'b1, 3, 11, 0);
        start = 1'b1; prec = CW'(4); sgn = 1'b1; sum_o_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; sum_o_ready = 1'b0;
        check("restart_busy", longint'(busy), 1);
        check("restart_valid_clear", longint'(sum_o_valid), 0);
        feed_bits(0, 1'b0, 0);
        merge_check(1, 0, "restart");
        accept();

        // Saturation: sh = 0x20 merged with 0x7FFFFFF0
        build(6, 1'b0, 1, 32, 64'h7FFF_FFF0);
        check("model_sat", exp_res, 64'h7FFF_FFFF);
        begin_mac(6, 1'b0);
        feed_bits(1, 1'b0, 64'h7FFF_FFF0);
        merge_check(0, 64'h7FFF_FFF0, "sat");
        accept();
        build(4, 1'b0, 3, 11, 100);
        begin_mac(4, 1'b0);
        feed_bits(0, 1'b1, 100);
        merge_check(0, 100, "ovf_sticky");
        accept();
        do_clr();
        check("ovf_cleared", longint'(ovf), 0);

        // Clear in mid-SHIFT with a simultaneous start
        build(8, 1'b0, 7, 8'hA5, 5);
        begin_mac(8, 1'b0);
        pp_valid = 1'b1; pp = 7;
        @(negedge clk);
        pp_valid = 1'b0; clr = 1'b1; start = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0; m_ovf = 1'b0;
        check("clr_busy", longint'(busy), 0);
        check("clr_sum", longint'(sum_o), 0);
        check("clr_valid", longint'(sum_o_valid), 0);
        build(5, 1'b1, -9, 5'b10011, -20);
        begin_mac(5, 1'b1);
        feed_bits(0, 1'b0, -20);
        merge_check(2, -20, "after_clr");
        accept();

        // Asynchronous reset while waiting in MERGE
        build(3, 1'b0, 11, 3'b101, 1);
        begin_mac(3, 1'b0);
        feed_bits(0, 1'b0, 1);
        #2 rst_n = 1'b0;
        #1;
        m_ovf = 1'b0;
        check("arst_busy", longint'(busy), 0);
        check("arst_sum", longint'(sum_o), 0);
        check("arst_valid", longint'(sum_o_valid), 0);
        check("arst_ready", longint'(sum_i_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build(0, 1'b0, 2, 16'hFFFF, 0);
        begin_mac(0, 1'b0);
        feed_bits(0, 1'b1, 0);
        merge_check(0, 0, "after_arst");
        accept();

        // Randomized MACs, including out-of-range precision and saturation
        for (int n = 0; n < 40; n++) begin
            int     p_raw = $urandom_range(0, (1 << CW) - 1);
            bit     s     = 1'($urandom);
            longint mcand = ($urandom % 2) ? longint'(int'($urandom)) :
                                             longint'(shortint'($urandom));
            longint mult  = longint'($urandom) & 64'hFFFF;
            longint sumi  = longint'(int'($urandom));
            int     gap   = $urandom_range(0, 2);
            int     late  = $urandom_range(0, 3);
            build(p_raw, s, mcand, mult, sumi);
            begin_mac(p_raw, s);
            feed_bits(gap, (late == 0), sumi);
            merge_check(late, sumi, "rand");
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("rand_hold", longint'(sum_o), exp_res);
            end
            accept();
            if ($urandom % 8 == 0) do_clr();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
